fp_alu_issue_ctrl: RTL and testbench

//  Sequencing front/back end for the combinational 32-bit IEEE-754 FP ALU. Buffers op commands in a

---
 rtl/fp_alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_fp_alu_issue_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_issue_ctrl.sv
// rtl/fp_alu_issue_ctrl.sv - command FIFO, issue sequencer and result capture around a combinational FP ALU
//
// Commands are queued in a small FIFO and handed to the ALU one at a time.
// The ALU operands are held stable for SETTLE_CYCLES cycles so the deep
// mul/div paths have settled before the result and flags are captured.
// Illegal opcodes never reach the ALU and return a zero result with the
// illegal flag set. Flag vectors are ordered {illegal, exc, ovf, unf}.

module fp_alu_issue_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_exc,
    input  logic             alu_ovf,
    input  logic             alu_unf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [3:0]       res_flags,
    output logic [TAG_W-1:0] res_tag,
    output logic [3:0]       sticky_flags,
    input  logic             flag_clear
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ENT_W = 4 + 32 + 32 + TAG_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ILLEGAL,
        S_HOLD
    } state_t;

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    logic [ENT_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [3:0]       w_head_op;
    logic [31:0]      w_head_a;
    logic [31:0]      w_head_b;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_head_legal;

    // Sequencer state and registered outputs
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [TAG_W-1:0] r_cur_tag;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic [3:0]       r_res_flags;
    logic [TAG_W-1:0] r_res_tag;
    logic [3:0]       r_sticky;

    logic             w_issue_last;
    logic             w_capture;
    logic [3:0]       w_new_flags;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Held low while in reset so nothing is offered to an upstream that is also resetting
    assign cmd_ready = rst_n && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;

    assign w_head       = r_fifo_mem[r_rd_ptr[AW-1:0]];
    assign w_head_op    = w_head[ENT_W-1 -: 4];
    assign w_head_a     = w_head[TAG_W+63 -: 32];
    assign w_head_b     = w_head[TAG_W+31 -: 32];
    assign w_head_tag   = w_head[TAG_W-1:0];
    assign w_head_legal = (w_head_op >= 4'd1) && (w_head_op <= 4'd11);

    assign w_issue_last = (r_state == S_ISSUE) && (r_cnt == CNT_LAST);
    assign w_capture    = w_issue_last || (r_state == S_ILLEGAL);
    assign w_new_flags  = (r_state == S_ILLEGAL) ? 4'b1000
                                                 : {1'b0, alu_exc, alu_ovf, alu_unf};

    // FIFO pointer update; push and pop may coincide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO payload write; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    // Issue FSM: pop, hold ALU inputs for the settle window, capture, wait for consumer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_tag   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_cur_tag <= w_head_tag;
                        r_cnt     <= '0;
                        if (w_head_legal) begin
                            r_alu_a  <= w_head_a;
                            r_alu_b  <= w_head_b;
                            r_alu_op <= w_head_op;
                            r_state  <= S_ISSUE;
                        end else begin
                            r_state  <= S_ILLEGAL;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue_last) begin
                        r_res_data  <= alu_result;
                        r_res_flags <= w_new_flags;
                        r_res_tag   <= r_cur_tag;
                        r_res_valid <= 1'b1;
                        r_alu_op    <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ILLEGAL: begin
                    r_res_data  <= '0;
                    r_res_flags <= w_new_flags;
                    r_res_tag   <= r_cur_tag;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flags; a capture on the clearing edge survives the clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (w_capture && flag_clear) begin
            r_sticky <= w_new_flags;
        end else if (flag_clear) begin
            r_sticky <= '0;
        end else if (w_capture) begin
            r_sticky <= r_sticky | w_new_flags;
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_flags    = r_res_flags;
    assign res_tag      = r_res_tag;
    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fp_alu_issue_ctrl.sv
// tb/tb_fp_alu_issue_ctrl.sv - scoreboard bench for fp_alu_issue_ctrl with a settling ALU stub

module tb_fp_alu_issue_ctrl;

    localparam int TAG_W  = 4;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_exc;
    logic             alu_ovf;
    logic             alu_unf;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic [3:0]       res_flags;
    logic [TAG_W-1:0] res_tag;
    logic [3:0]       sticky_flags;
    logic             flag_clear = 1'b0;

    always #5 clk = ~clk;

    fp_alu_issue_ctrl #(
        .FIFO_DEPTH(4),
        .SETTLE_CYCLES(SETTLE),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_tag(cmd_tag),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_exc(alu_exc),
        .alu_ovf(alu_ovf),
        .alu_unf(alu_unf),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_flags(res_flags),
        .res_tag(res_tag),
        .sticky_flags(sticky_flags),
        .flag_clear(flag_clear)
    );

    // ALU stub: output is garbage until its inputs have been stable long enough
    logic [67:0] stub_prev = '1;
    int          stub_stable = 0;
    logic        stub_settled;

    always @(posedge clk) begin
        if ({alu_op, alu_a, alu_b} != stub_prev) begin
            stub_prev   <= {alu_op, alu_a, alu_b};
            stub_stable <= 1;
        end else if (stub_stable < 1000) begin
            stub_stable <= stub_stable + 1;
        end
    end

    assign stub_settled = ({alu_op, alu_a, alu_b} == stub_prev) && (stub_stable >= SETTLE - 1);

    always_comb begin
        alu_result = 32'hDEADBEEF;
        alu_exc    = 1'b0;
        alu_ovf    = 1'b0;
        alu_unf    = 1'b0;
        if (alu_op != 4'd0 && !stub_settled) begin
            alu_result = 32'hBAD0BAD0;
        end else begin
            case (alu_op)
                4'd1: begin
                    alu_result = 32'h0;
                    if (alu_a == 32'h7F000000 && alu_b == 32'h7F000000) begin
                        alu_result = 32'h7F800000;
                        alu_ovf    = 1'b1;
                    end
                end
                4'd2: begin
                    alu_result = 32'h0;
                    if (alu_b == 32'h0) begin
                        alu_result = 32'h7F800000;
                        alu_exc    = 1'b1;
                    end
                end
                4'd4:  alu_result = alu_a | alu_b;
                4'd5:  alu_result = alu_a & alu_b;
                4'd6:  alu_result = alu_a ^ alu_b;
                4'd7:  alu_result = alu_a << alu_b[4:0];
                4'd8:  alu_result = alu_a >> alu_b[4:0];
                4'd10: alu_result = (alu_a == 32'h3F800000 && alu_b == 32'h40000000) ? 32'h40400000 : 32'h0;
                4'd11: alu_result = ~alu_a;
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic [31:0]      data;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      ed;
        logic [3:0]       ef;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got data 0x%0h tag %0d, expected no result", res_data, res_tag);
            end else begin
                check("res_data", res_data, sb[0].data);
                check("res_flags", res_flags, sb[0].flags);
                check("res_tag", res_tag, sb[0].tag);
                sb.delete(0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] ed, input logic [3:0] ef);
        bit ok = 1'b0;
        bit rdy;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        for (int i = 0; i < 300 && !ok; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                sb.push_back(exp_t'({ed, ef, tag}));
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: tag %0d not accepted, expected acceptance", tag);
        end
    endtask

    task automatic wait_drain();
        int i = 0;
        while ((sb.size() != 0 || res_valid) && i < 500) begin
            @(negedge clk);
            i++;
        end
        if (i >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic clear_sticky();
        flag_clear = 1'b1;
        @(negedge clk);
        flag_clear = 1'b0;
    endtask

    vec_t vecs[7];
    int   lat;
    bit   bad;
    logic [31:0]      hold_d;
    logic [TAG_W-1:0] hold_t;

    initial begin
        vecs[0] = '{4'd4,  32'h0F0F0000, 32'h00FF00FF, 4'd4,  32'h0FFF00FF, 4'b0000};
        vecs[1] = '{4'd6,  32'hFFFF0000, 32'h0F0F0F0F, 4'd5,  32'hF0F00F0F, 4'b0000};
        vecs[2] = '{4'd7,  32'h00000001, 32'h00000004, 4'd6,  32'h00000010, 4'b0000};
        vecs[3] = '{4'd8,  32'h80000000, 32'h0000001F, 4'd7,  32'h00000001, 4'b0000};
        vecs[4] = '{4'd11, 32'h12345678, 32'h00000000, 4'd8,  32'hEDCBA987, 4'b0000};
        vecs[5] = '{4'd5,  32'hF0F0F0F0, 32'h3C3C3C3C, 4'd9,  32'h30303030, 4'b0000};
        vecs[6] = '{4'd2,  32'h3F800000, 32'h00000000, 4'd10, 32'h7F800000, 4'b0100};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("rst_res", {res_data, res_flags, res_tag}, 0);
        check("rst_sticky", sticky_flags, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Add latency: result valid after edge 1+SETTLE
        res_ready = 1'b1;
        push(4'd10, 32'h3F800000, 32'h40000000, 4'd1, 32'h40400000, 4'b0000);
        lat = 0;
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("add_latency", lat, 5);
        @(negedge clk);
        wait_drain();

        // Illegal opcode: two-edge latency, ALU never driven, sticky illegal set
        push(4'd13, 32'h11111111, 32'h22222222, 4'd3, 32'h0, 4'b1000);
        lat = 0;
        bad = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (alu_op != 4'd0) bad = 1'b1;
        end
        check("illegal_latency", lat, 2);
        check("illegal_alu_op_idle", bad, 0);
        @(negedge clk);
        wait_drain();
        check("sticky_illegal", sticky_flags, 4'b1000);
        clear_sticky();
        check("sticky_clear_1", sticky_flags, 4'b0000);

        // Multiply overflow
        push(4'd1, 32'h7F000000, 32'h7F000000, 4'd2, 32'h7F800000, 4'b0010);
        wait_drain();
        check("sticky_ovf", sticky_flags, 4'b0010);

        // Capture and clear on the same edge keeps only the new event
        push(4'd2, 32'h3F800000, 32'h00000000, 4'd11, 32'h7F800000, 4'b0100);
        repeat (4) @(negedge clk);
        flag_clear = 1'b1;
        @(negedge clk);
        flag_clear = 1'b0;
        check("sticky_clear_with_capture", sticky_flags, 4'b0100);
        wait_drain();
        clear_sticky();
        check("sticky_clear_2", sticky_flags, 4'b0000);

        // Back-to-back mixed vectors
        foreach (vecs[i]) push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].ed, vecs[i].ef);
        wait_drain();
        check("sticky_batch", sticky_flags, 4'b0100);

        // Backpressure: five accepted, FIFO full, sixth held while result is stalled
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'd4, 32'(i), 32'hA5000000, TAG_W'(i + 1), 32'hA5000000 | 32'(i), 4'b0000);
        end
        check("fifo_full_ready", cmd_ready, 0);
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        check("stall_res_valid", res_valid, 1);
        hold_d = res_data;
        hold_t = res_tag;
        check("stall_first_data", hold_d, 32'hA5000000);
        bad = 1'b0;
        fork
            push(4'd6, 32'h0000FFFF, 32'h00FF00FF, 4'd6, 32'h00FFFF00, 4'b0000);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (!res_valid || res_data != hold_d || res_tag != hold_t || cmd_ready) bad = 1'b1;
                end
                check("hold_stable", bad, 0);
                res_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset during ISSUE with two commands queued
        push(4'd1, 32'h7F000000, 32'h7F000000, 4'd12, 32'h7F800000, 4'b0010);
        push(4'd4, 32'h1, 32'h2, 4'd13, 32'h3, 4'b0000);
        push(4'd4, 32'h4, 32'h8, 4'd14, 32'hC, 4'b0000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("midrst_res_valid", res_valid, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready_after", cmd_ready, 1);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid || alu_op != 4'd0) bad = 1'b1;
        end
        check("midrst_fifo_flushed", bad, 0);

        // Controller still works after the flush
        push(4'd10, 32'h3F800000, 32'h40000000, 4'd15, 32'h40400000, 4'b0000);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
